// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: forwarding-select codes and hazard FSM state.
package riscv_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'b10;
  localparam logic [1:0] FWD_MEM     = 2'b01;
  localparam logic [1:0] FWD_WB      = 2'b00;
  localparam logic [1:0] FWD_WB1     = 2'b11;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    LU_STALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/riscv_fwd_mux_sel.sv
// Forwarding-origin select for a single EX source operand (MEM > WB > WB+1 > regfile).
import riscv_pkg::*;

module riscv_fwd_mux_sel #(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb1_rd,
  input  logic              wb1_valid,
  output logic [1:0]        sel_c
);

  // Youngest producer wins; x0 is never a forwarding source.
  always_comb begin
    sel_c = FWD_REGFILE;
    if (mem_reg_write && !mem_mem_read && (mem_rd != '0) && (mem_rd == rs)) begin
      sel_c = FWD_MEM;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs)) begin
      sel_c = FWD_WB;
    end else if (wb1_valid && (wb1_rd != '0) && (wb1_rd == rs)) begin
      sel_c = FWD_WB1;
    end
  end

endmodule

// File: rtl/riscv_hazard_fwd_unit.sv
// Hazard/forwarding unit: per-operand forward selects, load-use stall FSM, branch flush.
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
import riscv_pkg::*;

module riscv_hazard_fwd_unit #(
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic                      ex_reg_write,
  input  logic                      ex_mem_read,
  input  logic                      ex_branch_taken,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic                      mem_reg_write,
  input  logic                      mem_mem_read,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic                      wb_reg_write,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall_pc,
  output logic                      stall_if_id,
  output logic                      bubble_id_ex,
  output logic                      flush_if_id,
  output logic                      flush_id_ex
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]               lu_stall_cnt,
  output logic [31:0]               flush_cnt
`endif
);

  localparam int unsigned CNT_W = 3;

  logic [REG_AW-1:0]    wb1_rd;
  logic                 wb1_valid;
  logic [2*NUM_SRC-1:0] fwd_raw;
  logic                 src_hit;
  logic                 lu_hit;
  hz_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 stall_c;

  // WB+1 history for a register file without write-through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb1_rd    <= '0;
      wb1_valid <= 1'b0;
    end else begin
      wb1_rd    <= wb_rd;
      wb1_valid <= wb_reg_write;
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    riscv_fwd_mux_sel #(.REG_AW(REG_AW)) u_sel (
      .rs            (ex_rs[g*REG_AW +: REG_AW]),
      .mem_rd        (mem_rd),
      .mem_reg_write (mem_reg_write),
      .mem_mem_read  (mem_mem_read),
      .wb_rd         (wb_rd),
      .wb_reg_write  (wb_reg_write),
      .wb1_rd        (wb1_rd),
      .wb1_valid     (wb1_valid),
      .sel_c         (fwd_raw[2*g +: 2])
    );
  end

  always_comb begin
    src_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (id_rs_used[i] && (id_rs[i*REG_AW +: REG_AW] == ex_rd)) src_hit = 1'b1;
    end
  end

  assign lu_hit = ex_mem_read && ex_reg_write && (ex_rd != '0) && src_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // First stall cycle is taken in IDLE; LU_STALL covers the remaining LOAD_LAT-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    if (ex_branch_taken) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lu_hit) begin
            stall_c = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = LU_STALL;
              cnt_d   = CNT_W'(LOAD_LAT - 1);
            end
          end
        end
        LU_STALL: begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are forced to their safe values while reset is held.
  assign fwd_sel      = rst ? {NUM_SRC{FWD_REGFILE}} : fwd_raw;
  assign stall_pc     = stall_c && !rst;
  assign stall_if_id  = stall_c && !rst;
  assign bubble_id_ex = stall_c && !rst;
  assign flush_if_id  = ex_branch_taken && !rst;
  assign flush_id_ex  = ex_branch_taken && !rst;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_stall_cnt <= '0;
      flush_cnt    <= '0;
    end else begin
      if (stall_pc && (lu_stall_cnt != 32'hFFFF_FFFF)) lu_stall_cnt <= lu_stall_cnt + 32'd1;
      if (flush_id_ex && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_hazard_fwd_unit.sv
// Bench for riscv_hazard_fwd_unit: LOAD_LAT=1 and LOAD_LAT=3 instances against a remaining-cycles model.
module tb_riscv_hazard_fwd_unit;

  localparam int unsigned NS = 2;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic rst;
  logic [NS*AW-1:0] id_rs, ex_rs;
  logic [NS-1:0]    id_rs_used;
  logic [AW-1:0]    ex_rd, mem_rd, wb_rd;
  logic ex_reg_write, ex_mem_read, ex_branch_taken;
  logic mem_reg_write, mem_mem_read, wb_reg_write;

  logic [2*NS-1:0] fwd_sel [2];
  logic stall_pc [2], stall_if_id [2], bubble_id_ex [2], flush_if_id [2], flush_id_ex [2];
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_cnt [2], fl_cnt [2];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Model state
  int            rem [2];
  int            lat [2];
  logic [AW-1:0] m_wb1_rd;
  logic          m_wb1_v;
  longint        m_lu [2], m_fl [2];

  always #5 clk = ~clk;

  riscv_hazard_fwd_unit #(.NUM_SRC(NS), .REG_AW(AW), .LOAD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_rs(ex_rs),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .fwd_sel(fwd_sel[0]), .stall_pc(stall_pc[0]), .stall_if_id(stall_if_id[0]),
    .bubble_id_ex(bubble_id_ex[0]), .flush_if_id(flush_if_id[0]), .flush_id_ex(flush_id_ex[0])
`ifdef HAZARD_PERF_CNT_EN
    , .lu_stall_cnt(lu_cnt[0]), .flush_cnt(fl_cnt[0])
`endif
  );

  riscv_hazard_fwd_unit #(.NUM_SRC(NS), .REG_AW(AW), .LOAD_LAT(3)) u3 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(id_rs_used), .ex_rs(ex_rs),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
    .mem_mem_read(mem_mem_read), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .fwd_sel(fwd_sel[1]), .stall_pc(stall_pc[1]), .stall_if_id(stall_if_id[1]),
    .bubble_id_ex(bubble_id_ex[1]), .flush_if_id(flush_if_id[1]), .flush_id_ex(flush_id_ex[1])
`ifdef HAZARD_PERF_CNT_EN
    , .lu_stall_cnt(lu_cnt[1]), .flush_cnt(fl_cnt[1])
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [1:0] exp_sel(input logic [AW-1:0] s);
    if (mem_reg_write && !mem_mem_read && mem_rd != 0 && mem_rd == s) return 2'b01;
    if (wb_reg_write && wb_rd != 0 && wb_rd == s) return 2'b00;
    if (m_wb1_v && m_wb1_rd != 0 && m_wb1_rd == s) return 2'b11;
    return 2'b10;
  endfunction

  function automatic logic exp_hit();
    logic h = 1'b0;
    for (int i = 0; i < NS; i++)
      if (id_rs_used[i] && id_rs[i*AW +: AW] == ex_rd) h = 1'b1;
    return ex_mem_read && ex_reg_write && ex_rd != 0 && h;
  endfunction

  function automatic logic exp_stall(input int k);
    if (rst || ex_branch_taken) return 1'b0;
    if (rem[k] > 0) return 1'b1;
    return exp_hit();
  endfunction

  task automatic compare_now();
    logic [2*NS-1:0] ef;
    logic es, efl;
    for (int i = 0; i < NS; i++) ef[2*i +: 2] = rst ? 2'b10 : exp_sel(ex_rs[i*AW +: AW]);
    efl = ex_branch_taken && !rst;
    for (int k = 0; k < 2; k++) begin
      es = exp_stall(k);
      check($sformatf("fwd_sel[%0d]", k), 32'(fwd_sel[k]), 32'(ef));
      check($sformatf("stall_pc[%0d]", k), 32'(stall_pc[k]), 32'(es));
      check($sformatf("stall_if_id[%0d]", k), 32'(stall_if_id[k]), 32'(es));
      check($sformatf("bubble_id_ex[%0d]", k), 32'(bubble_id_ex[k]), 32'(es));
      check($sformatf("flush_if_id[%0d]", k), 32'(flush_if_id[k]), 32'(efl));
      check($sformatf("flush_id_ex[%0d]", k), 32'(flush_id_ex[k]), 32'(efl));
`ifdef HAZARD_PERF_CNT_EN
      check($sformatf("lu_stall_cnt[%0d]", k), lu_cnt[k], rst ? 32'd0 : 32'(m_lu[k]));
      check($sformatf("flush_cnt[%0d]", k), fl_cnt[k], rst ? 32'd0 : 32'(m_fl[k]));
`endif
    end
  endtask

  // Advance the model to the state it holds after the coming rising edge.
  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_lu[k] = 0;
        m_fl[k] = 0;
      end else begin
        m_lu[k] = m_lu[k] + longint'(exp_stall(k));
        m_fl[k] = m_fl[k] + longint'(ex_branch_taken);
      end
      if (rst || ex_branch_taken) rem[k] = 0;
      else if (rem[k] > 0)        rem[k] = rem[k] - 1;
      else if (exp_hit())         rem[k] = lat[k] - 1;
      else                        rem[k] = 0;
    end
    m_wb1_rd = rst ? '0 : wb_rd;
    m_wb1_v  = rst ? 1'b0 : wb_reg_write;
  endtask

  task automatic cyc();
    @(negedge clk);
    compare_now();
    model_update();
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    id_rs = '0; ex_rs = '0; id_rs_used = '0;
    ex_rd = '0; mem_rd = '0; wb_rd = '0;
    ex_reg_write = 0; ex_mem_read = 0; ex_branch_taken = 0;
    mem_reg_write = 0; mem_mem_read = 0; wb_reg_write = 0;
  endtask

  task automatic set_hit();
    clear();
    ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5'd3;
    id_rs[AW-1:0] = 5'd3; id_rs_used = 2'b01;
  endtask

  initial begin
    lat[0] = 1; lat[1] = 3;
    rem[0] = 0; rem[1] = 0;
    m_wb1_rd = '0; m_wb1_v = 0;
    m_lu[0] = 0; m_lu[1] = 0; m_fl[0] = 0; m_fl[1] = 0;

    // Reset with live hazards on the inputs: outputs must stay safe.
    rst = 1;
    set_hit();
    ex_branch_taken = 1;
    ex_rs[AW-1:0] = 5'd5; mem_rd = 5'd5; mem_reg_write = 1;
    cyc();
    check("rst_fwd", 32'(fwd_sel[0]), 32'h0000_000A);
    check("rst_stall", 32'(stall_pc[1]), 32'd0);
    check("rst_flush", 32'(flush_id_ex[0]), 32'd0);
    cyc();
    next(); rst = 0; clear();

    // MEM beats WB; loads in MEM cannot forward.
    next(); ex_rs[AW-1:0] = 5'd5; mem_rd = 5'd5; mem_reg_write = 1; wb_rd = 5'd5; wb_reg_write = 1;
    cyc(); check("mem_fwd", 32'(fwd_sel[0][1:0]), 32'd1);
    next(); mem_mem_read = 1;
    cyc(); check("mem_load_to_wb", 32'(fwd_sel[0][1:0]), 32'd0);

    // WB+1 history path and x0 exclusion.
    next(); clear(); wb_rd = 5'd7; wb_reg_write = 1;
    cyc();
    next(); wb_reg_write = 0; ex_rs[2*AW-1:AW] = 5'd7;
    cyc(); check("wb1_fwd", 32'(fwd_sel[0][3:2]), 32'd3);
    next(); clear(); wb_rd = 5'd0; wb_reg_write = 1;
    cyc();
    next(); wb_reg_write = 0; ex_rs[2*AW-1:AW] = 5'd0;
    cyc(); check("wb1_x0", 32'(fwd_sel[1][3:2]), 32'd2);

    // Load-use: second hit during a LOAD_LAT=3 stall does not extend it.
    next(); set_hit();
    cyc(); check("lu1_c1", 32'(stall_pc[0]), 32'd1); check("lu3_c1", 32'(bubble_id_ex[1]), 32'd1);
    next();
    cyc(); check("lu3_c2", 32'(stall_pc[1]), 32'd1);
    next(); id_rs_used = 2'b00;
    cyc(); check("lu3_c3", 32'(stall_if_id[1]), 32'd1); check("lu1_unused", 32'(stall_pc[0]), 32'd0);
    next();
    cyc(); check("lu3_c4", 32'(stall_pc[1]), 32'd0);

    // Flush beats stall, including mid-stall abort.
    next(); set_hit(); ex_branch_taken = 1;
    cyc(); check("br_flush", 32'(flush_if_id[1]), 32'd1); check("br_nostall", 32'(stall_pc[1]), 32'd0);
    next(); set_hit();
    cyc();
    next(); clear(); ex_branch_taken = 1;
    cyc(); check("abort_c2", 32'(stall_pc[1]), 32'd0); check("abort_flush", 32'(flush_id_ex[1]), 32'd1);
    next(); clear();
    cyc(); check("abort_idle", 32'(stall_pc[1]), 32'd0);

    // Asynchronous reset in the middle of a stall.
    next(); set_hit();
    cyc();
    next(); clear(); ex_rs[AW-1:0] = 5'd5; mem_rd = 5'd5; mem_reg_write = 1;
    #2; rst = 1; #1;
    compare_now();
    check("async_rst_stall", 32'(stall_pc[1]), 32'd0);
    check("async_rst_fwd", 32'(fwd_sel[1]), 32'h0000_000A);
    cyc();
    next(); rst = 0;
    cyc(); check("post_rst_idle", 32'(stall_pc[1]), 32'd0);

`ifdef HAZARD_PERF_CNT_EN
    next(); set_hit();
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i < 3) next();
    end
    next(); clear(); ex_branch_taken = 1;
    cyc();
    next();
    cyc();
    next(); clear();
    cyc();
    check("perf_lu4", lu_cnt[0], 32'd4);
    check("perf_fl2", fl_cnt[0], 32'd2);
    next(); rst = 1; #1;
    check("perf_rst_lu", lu_cnt[0], 32'd0);
    check("perf_rst_fl", fl_cnt[1], 32'd0);
    cyc();
    next(); rst = 0;
`endif

    // Randomised traffic over a small register set to provoke frequent hits.
    for (int n = 0; n < 3000; n++) begin
      next();
      id_rs           = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      ex_rs           = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      id_rs_used      = 2'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      mem_rd          = 5'($urandom_range(0, 3));
      wb_rd           = 5'($urandom_range(0, 3));
      ex_reg_write    = 1'($urandom_range(0, 1));
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      mem_reg_write   = 1'($urandom_range(0, 1));
      mem_mem_read    = ($urandom_range(0, 3) == 0);
      wb_reg_write    = 1'($urandom_range(0, 1));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
